// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and constants for the instruction fetch stage
package fetch_pkg;
   typedef enum logic [1:0] {IDLE, REQ, DRAIN} fetch_state_e;
   localparam int INSTR_BYTES = 4;
   localparam logic [31:0] ALIGN_MASK = 32'hFFFF_FFFC;
   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
   } fetch_entry_t;
endpackage

// File: rtl/fetch_queue.sv
// fetch_queue: synchronous FIFO of fetched {pc, instr} entries with flush
module fetch_queue
   import fetch_pkg::*;
#(
   parameter int DEPTH = 2
) (
   input  logic                   clock,
   input  logic                   reset_n,
   input  logic                   flush,
   input  logic                   push,
   input  logic                   pop,
   input  fetch_entry_t           wr_entry,
   output fetch_entry_t           rd_entry,
   output logic [$clog2(DEPTH):0] count,
   output logic                   empty,
   output logic                   full
);
   localparam int AW = $clog2(DEPTH);
   fetch_entry_t  mem [DEPTH];
   logic [AW-1:0] wr_ptr, rd_ptr;
   assign rd_entry = mem[rd_ptr];
   assign empty = count == '0;
   assign full = count == (AW+1)'(DEPTH);
   // pointers wrap naturally since DEPTH is a power of two; flush leaves data untouched
   always_ff @(posedge clock or negedge reset_n)
      if (!reset_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count <= '0;
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count <= '0;
      end else begin
         if (push) mem[wr_ptr] <= wr_entry;
         wr_ptr <= wr_ptr + AW'(push);
         rd_ptr <= rd_ptr + AW'(pop);
         count <= count + (AW+1)'(push) - (AW+1)'(pop);
      end
endmodule

// File: rtl/instruction_fetch.sv
// instruction_fetch: paced PC sequencing, one outstanding imem read, queued delivery to decode
module instruction_fetch
   import fetch_pkg::*;
#(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int QUEUE_DEPTH = 2
) (
   input  logic        clock,
   input  logic        reset_n,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ack,
   input  logic [31:0] imem_rdata,
   output logic        inst_valid,
   input  logic        inst_ready,
   output logic [31:0] inst_data,
   output logic [31:0] inst_pc,
   output logic [31:0] fetch_pc
);
   localparam int CW = $clog2(QUEUE_DEPTH) + 1;
   localparam logic [CW-1:0] LAST = CW'(QUEUE_DEPTH - 1);
   fetch_state_e  state, state_nxt;
   logic [31:0]   fetch_pc_nxt, addr_nxt, target, pc_inc;
   logic          push, pop, empty, full, more;
   logic [CW-1:0] count;
   fetch_entry_t  head;
   assign target = redirect_pc & ALIGN_MASK;
   assign pc_inc = fetch_pc + 32'(INSTR_BYTES);
   assign imem_req = state != IDLE;
   assign push = imem_ack && state == REQ && !redirect_valid;
   assign pop = inst_valid && inst_ready && !redirect_valid;
   assign more = pop || count < LAST;
   assign inst_valid = !empty;
   assign inst_data = head.instr;
   assign inst_pc = head.pc;
   fetch_queue #(.DEPTH(QUEUE_DEPTH)) u_queue (
      .clock    (clock),
      .reset_n  (reset_n),
      .flush    (redirect_valid),
      .push     (push),
      .pop      (pop),
      .wr_entry ('{pc: imem_addr, instr: imem_rdata}),
      .rd_entry (head),
      .count    (count),
      .empty    (empty),
      .full     (full)
   );
   // next fetch state: redirect wins; a new request only goes out when a queue slot is guaranteed
   always_comb begin
      state_nxt = state;
      fetch_pc_nxt = fetch_pc;
      addr_nxt = imem_addr;
      if (redirect_valid) begin
         fetch_pc_nxt = target;
         state_nxt = (state == IDLE || imem_ack) ? REQ : DRAIN;
         addr_nxt = state_nxt == REQ ? target : imem_addr;
      end else if (state == IDLE) begin
         state_nxt = full ? IDLE : REQ;
         addr_nxt = fetch_pc;
      end else if (imem_ack && state == REQ) begin
         fetch_pc_nxt = pc_inc;
         addr_nxt = pc_inc;
         state_nxt = more ? REQ : IDLE;
      end else if (imem_ack) begin
         state_nxt = REQ;
         addr_nxt = fetch_pc;
      end
   end
   // state, fetch PC and request address registers
   always_ff @(posedge clock or negedge reset_n)
      if (!reset_n) begin
         state <= IDLE;
         fetch_pc <= RESET_PC;
         imem_addr <= RESET_PC;
      end else begin
         state <= state_nxt;
         fetch_pc <= fetch_pc_nxt;
         imem_addr <= addr_nxt;
      end
endmodule

// File: tb/tb_instruction_fetch.sv
// tb_instruction_fetch: table-driven vectors plus directed drain/reset/wrap sequences
module tb_instruction_fetch;
   logic        clock = 0, reset_n = 0, redirect_valid = 0, inst_ready = 0;
   logic [31:0] redirect_pc = 0;
   logic        imem_req, imem_ack, inst_valid;
   logic [31:0] imem_addr, imem_rdata, inst_data, inst_pc, fetch_pc;
   logic        imem_req2, inst_valid2;
   logic [31:0] imem_addr2, imem_rdata2, inst_data2, inst_pc2, fetch_pc2;
   logic        ack_en = 1;
   int          lat = 0, wait_cnt, acks = 0, n_vec = 0, n_fail = 0, base;
   typedef struct {
      logic        rv;
      logic [31:0] rpc;
      logic        rdy;
      logic        req;
      logic [31:0] addr;
      logic        vld;
      logic [31:0] pc;
      logic [31:0] fpc;
   } vec_t;
   vec_t vt [12];
   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return a ^ {a[15:0], a[31:16]} ^ 32'h5A3C_96E1;
   endfunction
   always #5 clock = ~clock;
   assign imem_ack = ack_en && imem_req && wait_cnt >= lat;
   assign imem_rdata = mem_word(imem_addr);
   assign imem_rdata2 = mem_word(imem_addr2);
   // memory latency model: cycles the current request has been waiting
   always @(posedge clock or negedge reset_n)
      if (!reset_n) wait_cnt <= 0;
      else wait_cnt <= (imem_req && !imem_ack) ? wait_cnt + 1 : 0;
   // count accepted memory responses
   always @(posedge clock)
      if (reset_n && imem_req && imem_ack) acks <= acks + 1;
   instruction_fetch dut (
      .clock(clock), .reset_n(reset_n), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
      .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
      .inst_valid(inst_valid), .inst_ready(inst_ready), .inst_data(inst_data), .inst_pc(inst_pc),
      .fetch_pc(fetch_pc)
   );
   instruction_fetch #(.RESET_PC(32'hFFFF_FFF8)) dut_wrap (
      .clock(clock), .reset_n(reset_n), .redirect_valid(1'b0), .redirect_pc(32'h0),
      .imem_req(imem_req2), .imem_addr(imem_addr2), .imem_ack(imem_req2), .imem_rdata(imem_rdata2),
      .inst_valid(inst_valid2), .inst_ready(1'b1), .inst_data(inst_data2), .inst_pc(inst_pc2),
      .fetch_pc(fetch_pc2)
   );
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask
   task automatic step();
      @(posedge clock);
      #1;
   endtask
   task automatic do_reset();
      reset_n = 0;
      redirect_valid = 0;
      redirect_pc = 0;
      inst_ready = 0;
      repeat (2) @(posedge clock);
      @(negedge clock);
      reset_n = 1;
   endtask
   initial begin
      #100000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1);
   end
   initial begin
      vt[0]  = '{0, 0, 1, 1, 32'h0,   0, 32'h0,   32'h0};
      vt[1]  = '{0, 0, 1, 1, 32'h4,   1, 32'h0,   32'h4};
      vt[2]  = '{0, 0, 1, 1, 32'h8,   1, 32'h4,   32'h8};
      vt[3]  = '{0, 0, 1, 1, 32'hC,   1, 32'h8,   32'hC};
      vt[4]  = '{0, 0, 0, 0, 32'h10,  1, 32'h8,   32'h10};
      vt[5]  = '{0, 0, 0, 0, 32'h10,  1, 32'h8,   32'h10};
      vt[6]  = '{0, 0, 1, 0, 32'h10,  1, 32'hC,   32'h10};
      vt[7]  = '{0, 0, 1, 1, 32'h10,  0, 32'h0,   32'h10};
      vt[8]  = '{0, 0, 1, 1, 32'h14,  1, 32'h10,  32'h14};
      vt[9]  = '{1, 32'h103, 1, 1, 32'h100, 0, 32'h0, 32'h100};
      vt[10] = '{0, 0, 1, 1, 32'h104, 1, 32'h100, 32'h104};
      vt[11] = '{0, 0, 1, 1, 32'h108, 1, 32'h104, 32'h108};
      repeat (2) @(posedge clock);
      #1;
      chk("rst imem_req", 32'(imem_req), 0);
      chk("rst imem_addr", imem_addr, 0);
      chk("rst fetch_pc", fetch_pc, 0);
      chk("rst inst_valid", 32'(inst_valid), 0);
      chk("rst inst_data", inst_data, 0);
      chk("rst inst_pc", inst_pc, 0);
      do_reset();
      for (int i = 0; i < 12; i++) begin
         redirect_valid = vt[i].rv;
         redirect_pc = vt[i].rpc;
         inst_ready = vt[i].rdy;
         step();
         chk($sformatf("v%0d imem_req", i), 32'(imem_req), 32'(vt[i].req));
         chk($sformatf("v%0d imem_addr", i), imem_addr, vt[i].addr);
         chk($sformatf("v%0d inst_valid", i), 32'(inst_valid), 32'(vt[i].vld));
         chk($sformatf("v%0d fetch_pc", i), fetch_pc, vt[i].fpc);
         if (vt[i].vld) begin
            chk($sformatf("v%0d inst_pc", i), inst_pc, vt[i].pc);
            chk($sformatf("v%0d inst_data", i), inst_data, mem_word(vt[i].pc));
         end
      end
      redirect_valid = 0;
      // wrap-around at top of address space
      do_reset();
      inst_ready = 1;
      step();
      chk("wrap first addr", imem_addr2, 32'hFFFF_FFF8);
      step();
      chk("wrap pc0", inst_pc2, 32'hFFFF_FFF8);
      step();
      chk("wrap pc1", inst_pc2, 32'hFFFF_FFFC);
      step();
      chk("wrap pc2", inst_pc2, 32'h0000_0000);
      chk("wrap data2", inst_data2, mem_word(32'h0));
      chk("wrap valid", 32'(inst_valid2), 1);
      // back-pressure with 2-cycle memory: queue fills then fetch stops
      do_reset();
      lat = 2;
      base = acks;
      repeat (20) step();
      chk("bp acks", 32'(acks - base), 2);
      chk("bp imem_req", 32'(imem_req), 0);
      chk("bp inst_pc", inst_pc, 0);
      chk("bp inst_data", inst_data, mem_word(0));
      chk("bp fetch_pc", fetch_pc, 32'h8);
      inst_ready = 1;
      step();
      chk("bp pop pc", inst_pc, 32'h4);
      chk("bp pop req", 32'(imem_req), 0);
      step();
      chk("bp resume req", 32'(imem_req), 1);
      chk("bp resume addr", imem_addr, 32'h8);
      chk("bp resume empty", 32'(inst_valid), 0);
      inst_ready = 0;
      for (int k = 0; k < 30 && !(!imem_req && inst_valid); k++) step();
      chk("refill idle", 32'(imem_req), 0);
      chk("refill head", inst_pc, 32'h8);
      chk("refill fetch_pc", fetch_pc, 32'h10);
      redirect_valid = 1;
      redirect_pc = 32'h103;
      step();
      redirect_valid = 0;
      chk("redir idle valid", 32'(inst_valid), 0);
      chk("redir idle req", 32'(imem_req), 1);
      chk("redir idle addr", imem_addr, 32'h100);
      chk("redir idle fetch_pc", fetch_pc, 32'h100);
      // redirect with a request outstanding: drain old response
      do_reset();
      lat = 0;
      inst_ready = 1;
      for (int k = 0; k < 20 && imem_addr != 32'h10; k++) step();
      ack_en = 0;
      chk("drain setup addr", imem_addr, 32'h10);
      step();
      chk("drain hold req", 32'(imem_req), 1);
      redirect_valid = 1;
      redirect_pc = 32'h180;
      step();
      chk("drain addr kept", imem_addr, 32'h10);
      chk("drain fetch_pc", fetch_pc, 32'h180);
      chk("drain flushed", 32'(inst_valid), 0);
      redirect_pc = 32'h200;
      step();
      redirect_valid = 0;
      chk("drain re-redir addr", imem_addr, 32'h10);
      chk("drain re-redir fetch_pc", fetch_pc, 32'h200);
      ack_en = 1;
      step();
      chk("drain discard", 32'(inst_valid), 0);
      chk("drain new addr", imem_addr, 32'h200);
      step();
      chk("drain first valid", 32'(inst_valid), 1);
      chk("drain first pc", inst_pc, 32'h200);
      chk("drain first data", inst_data, mem_word(32'h200));
      // asynchronous reset in the middle of a request
      do_reset();
      step();
      step();
      ack_en = 0;
      chk("mid setup valid", 32'(inst_valid), 1);
      step();
      chk("mid setup req", 32'(imem_req), 1);
      #2;
      reset_n = 0;
      #1;
      chk("mid rst req", 32'(imem_req), 0);
      chk("mid rst valid", 32'(inst_valid), 0);
      chk("mid rst addr", imem_addr, 0);
      chk("mid rst fetch_pc", fetch_pc, 0);
      @(negedge clock);
      reset_n = 1;
      ack_en = 1;
      inst_ready = 1;
      step();
      chk("restart addr", imem_addr, 0);
      chk("restart req", 32'(imem_req), 1);
      step();
      chk("restart pc", inst_pc, 0);
      chk("restart valid", 32'(inst_valid), 1);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end
endmodule

// File: doc/instruction_fetch.md
# instruction_fetch

Fetch stage directly downstream of the program counter: holds the architectural PC, issues one 32-bit instruction-memory read per fetch, and queues returned words (with their PC) for the decode stage over a valid/ready handshake. It accepts PC redirects from the branch/jump unit, flushing queued and in-flight instructions. It replaces free-running PC increment with fetch-paced, back-pressure-aware sequencing.

## Interface
- RESET_PC, 32'h0000_0000, first fetch address after reset (bits [1:0] must be 0)
- QUEUE_DEPTH, 2, entries in the instruction queue (power of two, ≥2)

- clock  input  1  system clock; all state updates on rising edge
- reset_n  input  1  asynchronous, active-low reset
- redirect_valid  input  1  single-cycle pulse: load redirect_pc, flush
- redirect_pc  input  32  new fetch address; bits [1:0] ignored (forced to 0)
- imem_req  output  1  read request to instruction memory
- imem_addr  output  32  word-aligned read address; stable while imem_req high
- imem_ack  input  1  read complete; imem_rdata valid this cycle
- imem_rdata  input  32  instruction word
- inst_valid  output  1  queue head valid to decode
- inst_ready  input  1  decode accepts head
- inst_data  output  32  instruction word at queue head
- inst_pc  output  32  address of inst_data
- fetch_pc  output  32  address of next/current fetch

## Operation
- Reset values: imem_req 0, imem_addr RESET_PC, fetch_pc RESET_PC, inst_valid 0, inst_data 0, inst_pc 0, queue empty, state IDLE.
- FSM states:
  - IDLE: if (queue count + 0) < QUEUE_DEPTH, assert imem_req with imem_addr = fetch_pc, go REQ.
  - REQ: hold imem_req/imem_addr until imem_ack. On ack: push {imem_rdata, imem_addr}, fetch_pc += 4; if count after push/pop < QUEUE_DEPTH, issue next request back-to-back (stay REQ), else go IDLE.
  - DRAIN: entered on redirect while a request is outstanding without ack. Keep imem_req high at old address until ack; discard data; then issue at fetch_pc (the redirect target) in REQ.
- One outstanding request maximum; a request is issued only when a queue slot is guaranteed, so a push never hits a full queue.
- Queue: FIFO, push on accepted ack, pop on inst_valid && inst_ready; simultaneous push and pop permitted at any count.
- Redirect (any state): queue flushed (inst_valid 0 next cycle), fetch_pc ← {redirect_pc[31:2], 2'b00}. Redirect has priority over pop and push in the same cycle.
- Redirect coincident with imem_ack: returned word discarded, next request at redirect target the following cycle (state REQ, no DRAIN).
- Redirect while in DRAIN: update fetch_pc again, remain DRAIN.
- PC arithmetic modulo 2^32: 32'hFFFF_FFFC + 4 → 32'h0000_0000, no flag.
- Reset assertion mid-transaction: all state to reset values immediately; a pending memory response after reset is ignored (memory is reset by the same reset_n).

## Timing
- First imem_req high in the first clock edge after reset_n deasserts.
- ack at edge N → inst_valid high after edge N (1-cycle latency into queue, registered outputs).
- Zero-wait memory (ack same cycle as req) sustains one instruction per cycle when decode is always ready.
- Redirect at edge N → new imem_addr visible after edge N (IDLE/REQ-acked) or after the draining ack.
- inst_data/inst_pc stable while inst_valid && !inst_ready.

## Structure
- Shared package fetch_pkg: FSM state enum (IDLE, REQ, DRAIN), INSTR_BYTES = 4, word-alignment mask.
- Sub-module fetch_queue: parameterised-depth synchronous FIFO of {pc, instr}, with flush, push, pop, count, empty/full.

## Test plan
- Reset, RESET_PC=0, ack every cycle, inst_ready=1 → inst_pc 0,4,8,12… one per cycle, inst_data matches memory model.
- inst_ready=0 with 2-cycle ack latency → exactly QUEUE_DEPTH words queued, imem_req low afterwards; raising inst_ready resumes fetch at 0x8.
- Redirect to 0x103 while 2 entries queued and no request pending → inst_valid 0 next cycle, next imem_addr 0x100.
- Redirect to 0x200 while request to 0x10 outstanding (ack 3 cycles later) → 0x10 data discarded, next imem_addr 0x200, inst_pc never shows 0x10.
- RESET_PC=0xFFFF_FFF8 → inst_pc 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0000_0000.
- reset_n low mid-REQ → imem_req 0 and inst_valid 0 immediately; restart fetch at RESET_PC.
